seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 10 +
 rtl/seg7_hex.sv | 9 +
 rtl/seg7_scan.sv | 100 ++++++++++
 tb/tb_seg7_scan.sv | 128 ++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment glyph table and blank pattern.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // Entry k is the glyph for hex digit k (index 15 first in the concatenation).
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/seg7_hex.sv
// seg7_hex: combinational nibble-to-glyph decode.
module seg7_hex
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG_GLYPHS[hex];
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed hex display driver with frame-aligned value commit,
// leading-zero blanking and anode ghost blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 18
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_blank_lz,
    output logic                  o_ready,
    output logic [DIGITS-1:0]     o_an,
    output logic [6:0]            o_seg,
    output logic                  o_dp
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [DIV-1:0]      cnt;
    logic [IW-1:0]       idx;
    logic                pending;
    logic [4*DIGITS-1:0] pend_value, disp_value;
    logic [DIGITS-1:0]   pend_dp, disp_dp;
    logic                pend_blank, disp_blank;
    logic                tick, last, accept, commit, ghost, blank, dp_sel;
    logic [3:0]          nib;
    logic [6:0]          glyph;
    logic [IW-1:0]       msd;

    assign tick    = cnt == '0;
    assign last    = idx == IW'(DIGITS - 1);
    assign accept  = i_valid && !pending;
    assign commit  = pending && tick && last;
    assign o_ready = !pending;
    assign ghost   = &cnt[DIV-1:DIV-2];
    assign blank   = disp_blank && idx > msd;

    // msd tracks the most significant nonzero nibble; digit 0 is never above it.
    always_comb begin
        nib    = disp_value[3:0];
        dp_sel = disp_dp[0];
        msd    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib    = disp_value[4*k +: 4];
                dp_sel = disp_dp[k];
            end
            if (k > 0 && disp_value[4*k +: 4] != 4'h0) msd = IW'(k);
        end
    end

    seg7_hex u_hex (.hex(nib), .seg(glyph));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '1;
            idx <= '0;
        end else begin
            cnt <= tick ? '1 : cnt - 1'b1;
            if (tick) idx <= last ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending    <= 1'b0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_blank <= 1'b0;
        end else if (commit) begin
            pending    <= 1'b0;
            disp_value <= pend_value;
            disp_dp    <= pend_dp;
            disp_blank <= pend_blank;
        end else if (accept) begin
            pending    <= 1'b1;
            pend_value <= i_value;
            pend_dp    <= i_dp;
            pend_blank <= i_blank_lz;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_an  <= '1;
            o_seg <= SEG_BLANK;
            o_dp  <= 1'b1;
        end else begin
            o_an  <= ghost ? '1 : ~(DIGITS'(1) << idx);
            o_seg <= blank ? SEG_BLANK : glyph;
            o_dp  <= ~dp_sel;
        end
    end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed and random checks of seg7_scan (DIGITS=4, DIV=4)
// against a time-based reference model of the scan schedule.
module tb_seg7_scan;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_value = '0;
    logic [3:0]  i_dp = '0;
    logic        i_blank_lz = 1'b0;
    logic        o_ready;
    logic [3:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;

    int compared = 0;
    int mismatched = 0;

    // Model: e counts edges since reset release; each digit dwells 16 edges.
    int          e = 0;
    logic        pend = 1'b0, pblz = 1'b0, dblz = 1'b0;
    logic [15:0] pv = '0, dv = '0;
    logic [3:0]  pdp = '0, ddp = '0;

    logic [6:0] glyph_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan #(.DIGITS(4), .DIV(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_value(i_value),
        .i_dp(i_dp), .i_blank_lz(i_blank_lz), .o_ready(o_ready), .o_an(o_an),
        .o_seg(o_seg), .o_dp(o_dp)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s e=%0d observed %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    task automatic chk_blank();
        chk("rst_an", 32'(o_an), 32'hF);
        chk("rst_seg", 32'(o_seg), 32'h7F);
        chk("rst_dp", 32'(o_dp), 32'h1);
        chk("rst_ready", 32'(o_ready), 32'h1);
    endtask

    task automatic model_reset();
        e = 0; pend = 0; pv = '0; pdp = '0; pblz = 0; dv = '0; ddp = '0; dblz = 0;
    endtask

    task automatic step(input logic v, input logic [15:0] val, input logic [3:0] dp, input logic blz);
        int p, d;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic exp_dp;
        i_valid = v; i_value = val; i_dp = dp; i_blank_lz = blz;
        p = e % 16;
        d = (e / 16) % 4;
        exp_an  = p < 4 ? 4'hF : ~(4'b0001 << d);
        exp_seg = (dblz && d > 0 && (dv >> (4 * d)) == 16'h0) ? 7'h7F : glyph_ref[dv[4*d +: 4]];
        exp_dp  = ~ddp[d];
        if (pend && p == 15 && d == 3) begin
            dv = pv; ddp = pdp; dblz = pblz; pend = 0;
        end else if (v && !pend) begin
            pv = val; pdp = dp; pblz = blz; pend = 1;
        end
        e++;
        @(posedge i_clk);
        #1;
        chk("an", 32'(o_an), 32'(exp_an));
        chk("seg", 32'(o_seg), 32'(exp_seg));
        chk("dp", 32'(o_dp), 32'(exp_dp));
        chk("ready", 32'(o_ready), 32'(!pend));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    task automatic idle_until_digit(input int dig);
        for (int i = 0; i < 200 && (((e / 16) % 4) != dig || (e % 16) != 6); i++) idle(1);
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        chk_blank();
        i_rst_n = 1'b1;
        #1;
        chk_blank();
        model_reset();
        idle(80);
        // Commit mid-frame offer, then a second offer under back-pressure.
        idle_until_digit(1);
        step(1'b1, 16'h12AF, 4'h0, 1'b0);
        idle(5);
        step(1'b1, 16'h0000, 4'h0, 1'b0);
        idle(140);
        // Leading-zero blanking on and off.
        step(1'b1, 16'h0030, 4'h0, 1'b1);
        idle(140);
        step(1'b1, 16'h0030, 4'h0, 1'b0);
        idle(140);
        step(1'b1, 16'h5678, 4'b0100, 1'b0);
        idle(140);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, 16'($urandom), 4'($urandom), 1'($urandom));
        idle(140);
        // Reset during digit 2 with a value pending.
        idle_until_digit(2);
        step(1'b1, 16'hBEEF, 4'hF, 1'b0);
        chk("pending_before_rst", 32'(o_ready), 32'h0);
        i_rst_n = 1'b0;
        #1;
        chk_blank();
        @(posedge i_clk);
        #1;
        chk_blank();
        i_rst_n = 1'b1;
        model_reset();
        idle(140);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
